// File: rtl/bram_stream_reader.sv
// Burst reader: walks a block of BRAM words starting at base_addr and streams
// them out through a small FIFO with ready/valid backpressure.
module bram_stream_reader #(
   parameter int ADDR_W     = 10,
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   length,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_data_in,
   input  logic [DATA_W-1:0] mem_data_out,
   output logic [DATA_W-1:0] m_data,
   output logic              m_valid,
   input  logic              m_ready,
   output logic              m_last,
   output logic              busy,
   output logic              done
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int LW = ADDR_W + 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);
   localparam logic [LW-1:0] ONE_L   = {{(LW-1){1'b0}}, 1'b1};

   logic [1:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [LW-1:0]     remaining_q, remaining_d;
   logic [LW-1:0]     words_left_q, words_left_d;
   logic              issue_q, issue_d;
   logic              rvalid_q, rvalid_d;
   logic              done_q, done_d;
   logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
   logic [DATA_W-1:0] fifo_d [FIFO_DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;

   logic              push_s;
   logic              pop_s;
   logic              last_pop_s;
   logic [CW:0]       occ_s;
   logic              room_s;

   // Occupancy counts words already buffered plus reads still in the memory pipe.
   assign push_s     = rvalid_q;
   assign pop_s      = (count_q != {CW{1'b0}}) && m_ready;
   assign last_pop_s = pop_s && (words_left_q == ONE_L);
   assign occ_s      = {1'b0, count_q} + {{CW{1'b0}}, issue_q} + {{CW{1'b0}}, rvalid_q};
   assign room_s     = (occ_s < DEPTH_C);

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      remaining_d  = remaining_q;
      words_left_d = words_left_q;
      issue_d      = 1'b0;
      done_d       = 1'b0;
      rvalid_d     = issue_q;
      if (pop_s) begin
         words_left_d = words_left_q - ONE_L;
      end else begin
         words_left_d = words_left_q;
      end
      case (state_q)
         IDLE: begin
            if (start && (length == {LW{1'b0}})) begin
               done_d = 1'b1;
            end else if (start) begin
               state_d      = RUN;
               addr_d       = base_addr;
               issue_d      = 1'b1;
               remaining_d  = length - ONE_L;
               words_left_d = length;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (remaining_q == {LW{1'b0}}) begin
               state_d = DRAIN;
            end else if (room_s) begin
               issue_d     = 1'b1;
               addr_d      = addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               remaining_d = remaining_q - ONE_L;
            end else begin
               issue_d = 1'b0;
            end
         end
         DRAIN: begin
            state_d = DRAIN;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      if ((state_q != IDLE) && last_pop_s) begin
         state_d = IDLE;
         done_d  = 1'b1;
      end else begin
         done_d = done_d;
      end
   end

   // Output FIFO: capture one cycle after each issued address, pop on transfer.
   always_comb begin
      fifo_d   = fifo_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_s) begin
         fifo_d[wr_ptr_q] = mem_data_out;
         wr_ptr_d         = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
         2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
         2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         addr_q       <= {ADDR_W{1'b0}};
         remaining_q  <= {LW{1'b0}};
         words_left_q <= {LW{1'b0}};
         issue_q      <= 1'b0;
         rvalid_q     <= 1'b0;
         done_q       <= 1'b0;
         wr_ptr_q     <= {PW{1'b0}};
         rd_ptr_q     <= {PW{1'b0}};
         count_q      <= {CW{1'b0}};
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            fifo_q[i] <= {DATA_W{1'b0}};
         end
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         remaining_q  <= remaining_d;
         words_left_q <= words_left_d;
         issue_q      <= issue_d;
         rvalid_q     <= rvalid_d;
         done_q       <= done_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         fifo_q       <= fifo_d;
      end
   end

   assign mem_addr    = addr_q;
   assign mem_we      = 1'b0;
   assign mem_data_in = {DATA_W{1'b0}};
   assign m_data      = fifo_q[rd_ptr_q];
   assign m_valid     = (count_q != {CW{1'b0}});
   assign m_last      = m_valid && (words_left_q == ONE_L);
   assign busy        = (state_q != IDLE);
   assign done        = done_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Randomized bench for bram_stream_reader: a behavioural memory plus a
// queue of expected words derived from base/length arithmetic.
module tb_bram_stream_reader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [9:0]  base_addr;
   logic [10:0] length;
   logic [9:0]  mem_addr;
   logic        mem_we;
   logic [7:0]  mem_data_in;
   logic [7:0]  mem_data_out;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;
   logic        busy;
   logic        done;

   logic [7:0]  mem [1024];
   int          n_checks = 0;
   int          n_errors = 0;

   bram_stream_reader #(.ADDR_W(10), .DATA_W(8), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .length(length),
      .mem_addr(mem_addr), .mem_we(mem_we), .mem_data_in(mem_data_in),
      .mem_data_out(mem_data_out), .m_data(m_data), .m_valid(m_valid),
      .m_ready(m_ready), .m_last(m_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // memory with one-cycle registered read
   always @(posedge clk) mem_data_out <= mem[mem_addr];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_addr"}, 32'(mem_addr), 32'd0);
      check({tag, "_we"}, 32'(mem_we), 32'd0);
      check({tag, "_wdata"}, 32'(mem_data_in), 32'd0);
      check({tag, "_data"}, 32'(m_data), 32'd0);
      check({tag, "_valid"}, 32'(m_valid), 32'd0);
      check({tag, "_last"}, 32'(m_last), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
   endtask

   // mode 0: ready held 1, 1: ready pattern 1,0,0 repeating, 2: random ready
   task automatic do_burst(input logic [9:0] b, input logic [10:0] len, input int mode, input bit poke);
      logic [7:0] exp_q [$];
      logic [9:0] addr0;
      logic [7:0] prev_data;
      logic       prev_last;
      bit         stall, seen_done;
      int         first_c, last_c, c;
      exp_q.delete();
      for (int i = 0; i < int'(len); i++) exp_q.push_back(mem[(int'(b) + i) % 1024]);
      @(posedge clk); #1;
      addr0 = mem_addr;
      start = 1'b1; base_addr = b; length = len; m_ready = 1'b1;
      first_c = -1; last_c = -1; stall = 1'b0; seen_done = 1'b0;
      prev_data = 8'd0; prev_last = 1'b0;
      c = 0;
      while (!seen_done && c < 4 * int'(len) + 40) begin
         c++;
         @(posedge clk); #1;
         start = poke && (c == 2);
         if (poke) begin
            base_addr = 10'($urandom);
            length    = 11'($urandom_range(1, 50));
         end
         case (mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ((c - 1) % 3 == 0);
            default: m_ready = 1'($urandom);
         endcase
         @(negedge clk);
         if (mode == 0 && c <= int'(len)) check("issue_addr", 32'(mem_addr), 32'((int'(b) + c - 1) % 1024));
         if (len == 11'd0 && c == 1) check("zero_len_addr_hold", 32'(mem_addr), 32'(addr0));
         if (stall) begin
            check("hold_valid", 32'(m_valid), 32'd1);
            check("hold_data", 32'(m_data), 32'(prev_data));
            check("hold_last", 32'(m_last), 32'(prev_last));
         end
         if (done) begin
            seen_done = 1'b1;
            check("done_cycle", c, (len == 11'd0) ? 1 : last_c + 1);
            check("busy_at_done", 32'(busy), 32'd0);
         end else begin
            check("busy", 32'(busy), 32'(len != 11'd0));
         end
         stall = 1'b0;
         if (m_valid) begin
            if (first_c < 0) begin
               first_c = c;
               check("first_valid_cycle", c, 3);
            end
            if (exp_q.size() == 0) begin
               check("extra_word", 32'(m_valid), 32'd0);
            end else if (m_ready) begin
               check("data", 32'(m_data), 32'(exp_q[0]));
               check("last", 32'(m_last), 32'(exp_q.size() == 1));
               if (exp_q.size() == 1) last_c = c;
               void'(exp_q.pop_front());
            end else begin
               stall = 1'b1; prev_data = m_data; prev_last = m_last;
            end
         end
      end
      check("words_left", exp_q.size(), 0);
      check("done_seen", 32'(seen_done), 32'd1);
      if (len == 11'd0) check("zero_len_no_valid", first_c, -1);
      if (mode == 0 && len != 11'd0) check("throughput_last_cycle", last_c, int'(len) + 2);
      start = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("idle_valid", 32'(m_valid), 32'd0);
         check("idle_done", 32'(done), 32'd0);
         check("idle_busy", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      int nx;
      rst = 1'b1; start = 1'b0; base_addr = 10'd0; length = 11'd0; m_ready = 1'b0;
      for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
      mem[10] = 8'h80; mem[11] = 8'hFF;
      repeat (3) @(posedge clk);
      #1; rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("reset");

      do_burst(10'd5, 11'd4, 0, 1'b0);
      do_burst(10'h3FE, 11'd4, 0, 1'b0);
      do_burst(10'd20, 11'd6, 1, 1'b0);
      do_burst(10'd10, 11'd2, 0, 1'b0);
      do_burst(10'd77, 11'd0, 0, 1'b0);
      do_burst(10'd100, 11'd5, 0, 1'b1);

      for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
      for (int k = 0; k < 8; k++)
         do_burst(10'($urandom), 11'($urandom_range(1, 40)), 1 + (k % 2), 1'b0);
      do_burst(10'($urandom), 11'd1, 2, 1'b0);
      do_burst(10'd300, 11'd1024, 0, 1'b0);

      // abort after two words of an eight-word burst
      @(posedge clk); #1;
      start = 1'b1; base_addr = 10'd200; length = 11'd8; m_ready = 1'b1;
      nx = 0;
      for (int c = 1; c < 20 && nx < 2; c++) begin
         @(posedge clk); #1; start = 1'b0;
         @(negedge clk);
         if (m_valid && m_ready) nx++;
      end
      check("pre_abort_words", nx, 2);
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      @(negedge clk);
      check_reset_outputs("abort");
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         @(negedge clk);
         check("abort_no_done", 32'(done), 32'd0);
         check("abort_no_valid", 32'(m_valid), 32'd0);
      end
      do_burst(10'd500, 11'd7, 2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
